// File: rtl/latex_uart_tx_pkg.sv
// rtl/latex_uart_tx_pkg.sv - shared encodings and constants for the UART transmitter
package latex_uart_tx_pkg;

  // Serialiser states. CR and LF frames run through START/DATA/STOP;
  // the suffix counter below selects which byte they carry, so ST_CR and
  // ST_LF only name the encodings and are never entered.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_CR    = 3'd4,
    ST_LF    = 3'd5
  } uart_state_e;

  // Which suffix frame, if any, is currently on the line.
  typedef enum logic [1:0] {
    SFX_NONE = 2'd0,
    SFX_CR   = 2'd1,
    SFX_LF   = 2'd2
  } suffix_e;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic       START_BIT = 1'b0;
  localparam logic       STOP_BIT  = 1'b1;

endpackage

// File: rtl/latex_uart_tx_char_fifo.sv
// rtl/latex_uart_tx_char_fifo.sv - synchronous show-ahead FIFO with occupancy output
module char_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  // Full/empty come from registered occupancy only, so a write while full
  // is dropped even if a read frees a slot on the same edge.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];
  assign do_wr   = wr_en && !full && !rst;
  assign do_rd   = rd_en && !empty && !rst;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/latex_uart_tx.sv
// rtl/latex_uart_tx.sv - buffered 8N1 UART transmitter with CR/LF after end-of-string
module latex_uart_tx
  import latex_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    char_in,
  input  logic                          char_eos,
  input  logic                          char_valid,
  output logic                          char_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state_q, state_d;
  suffix_e          sfx_q, sfx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             eos_q, eos_d;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic [8:0]       fifo_rd;
  logic             bit_done;

  assign char_ready = !fifo_full;
  assign push       = char_valid && char_ready;
  assign bit_done   = (cnt_q == '0);
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign tx         = (state_q == ST_START) ? START_BIT :
                      (state_q == ST_DATA)  ? shift_q[0] : STOP_BIT;

  char_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({char_eos, char_in}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Serialiser state, baud counter, bit index and shifter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sfx_q   <= SFX_NONE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      eos_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sfx_q   <= sfx_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      eos_q   <= eos_d;
    end
  end

  // Next-state logic: bit timing, frame sequencing and suffix insertion.
  always_comb begin
    state_d = state_q;
    sfx_d   = sfx_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    eos_d   = eos_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd[7:0];
          eos_d   = fifo_rd[8];
          sfx_d   = SFX_NONE;
          cnt_d   = CNT_RELOAD;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          cnt_d   = CNT_RELOAD;
          idx_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_d   = CNT_RELOAD;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          // Last stop-bit cycle: chain straight into the next frame so
          // suffixes and queued bytes follow with no idle gap.
          cnt_d = CNT_RELOAD;
          if (eos_q && (sfx_q == SFX_NONE)) begin
            shift_d = ASCII_CR;
            sfx_d   = SFX_CR;
            state_d = ST_START;
          end else if (sfx_q == SFX_CR) begin
            shift_d = ASCII_LF;
            sfx_d   = SFX_LF;
            state_d = ST_START;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rd[7:0];
            eos_d   = fifo_rd[8];
            sfx_d   = SFX_NONE;
            state_d = ST_START;
          end else begin
            sfx_d   = SFX_NONE;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        sfx_d   = SFX_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_latex_uart_tx.sv
// tb/tb_latex_uart_tx.sv - randomized self-checking bench with UART receiver model
module tb_latex_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] char_in;
  logic       char_eos, char_valid, char_ready, tx, busy;
  logic [3:0] fifo_level;
  logic [7:0] s_char_in;
  logic       s_eos, s_valid, s_ready, s_tx, s_busy;
  logic [1:0] s_level;

  int pass_cnt = 0;
  int total_cnt = 0;

  bit   cap_a[$];
  bit   busy_a[$];
  bit   cap_b[$];
  bit   cap_en = 0;
  bit   cap_en_s = 0;
  int   lvl_max = 0;
  int   rdy_bad = 0;
  logic [7:0] dec_b[$];
  int   dec_s[$];
  int   dec_bad;

  latex_uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_eos(char_eos),
    .char_valid(char_valid), .char_ready(char_ready), .tx(tx),
    .busy(busy), .fifo_level(fifo_level)
  );

  latex_uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(2)) dut_s (
    .clk(clk), .rst(rst), .char_in(s_char_in), .char_eos(s_eos),
    .char_valid(s_valid), .char_ready(s_ready), .tx(s_tx),
    .busy(s_busy), .fifo_level(s_level)
  );

  always #5 clk = ~clk;

  // Line monitor: record tx/busy and watch occupancy rules away from the edge.
  always @(negedge clk) begin
    if (cap_en) begin
      cap_a.push_back(tx);
      busy_a.push_back(busy);
      if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
      if (char_ready !== (fifo_level != 4'd8)) rdy_bad++;
    end
    if (cap_en_s) cap_b.push_back(s_tx);
  end

  // Generic 8N1 receiver: find a falling edge, sample each bit at its centre.
  task automatic decode(input int sel, input int cpb);
    bit w[$];
    int i;
    logic [7:0] v;
    if (sel == 0) w = cap_a; else w = cap_b;
    dec_b.delete();
    dec_s.delete();
    dec_bad = 0;
    i = 0;
    while (i < w.size()) begin
      if (w[i] == 1'b0) begin
        if (i + 10*cpb > w.size()) begin
          dec_bad++;
          break;
        end
        for (int j = 0; j < 8; j++) v[j] = w[i + (j+1)*cpb + cpb/2];
        if (w[i + cpb/2] != 1'b0 || w[i + 9*cpb + cpb/2] != 1'b1) dec_bad++;
        dec_b.push_back(v);
        dec_s.push_back(i);
        i = i + 9*cpb + cpb/2 + 1;
      end else begin
        i++;
      end
    end
  endtask

  task automatic start_cap();
    @(posedge clk);
    cap_a.delete();
    busy_a.delete();
    lvl_max = 0;
    rdy_bad = 0;
    cap_en = 1;
    @(negedge clk);
  endtask

  task automatic stop_cap();
    repeat (4) @(negedge clk);
    #1 cap_en = 0;
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic e);
    int guard;
    char_in = b;
    char_eos = e;
    char_valid = 1;
    guard = 0;
    while (char_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      total_cnt++;
      $display("FAIL push_timeout: byte %0h never accepted", b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int guard;
    guard = 0;
    while (busy !== 1'b0 && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= limit) begin
      total_cnt++;
      $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, limit);
    end
  endtask

  function automatic int first_idle();
    for (int k = 1; k < busy_a.size(); k++) if (busy_a[k] == 1'b0) return k;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1;
    char_valid = 1;
    char_in = 8'hFF;
    s_valid = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (tx !== 1'b1) $display("FAIL reset_tx: got %0b want 1", tx); else pass_cnt++;
    total_cnt++; if (char_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", char_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (fifo_level !== 4'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else pass_cnt++;
    total_cnt++; if (s_tx !== 1'b1 || s_level !== 2'd0) $display("FAIL reset_small: tx %0b level %0d want 1/0", s_tx, s_level); else pass_cnt++;
    char_valid = 0;
    s_valid = 0;
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] got;
    start_cap();
    push_byte(8'h41, 1'b0);
    char_valid = 0;
    wait_idle(400);
    stop_cap();
    decode(0, 16);
    got = (dec_b.size() > 0) ? dec_b[0] : 8'hxx;
    total_cnt++; if (dec_b.size() != 1) $display("FAIL single_count: got %0d want 1", dec_b.size()); else pass_cnt++;
    total_cnt++; if (got !== 8'h41) $display("FAIL single_byte: got %0h want 41", got); else pass_cnt++;
    total_cnt++; if (dec_s.size() < 1 || dec_s[0] != 2) $display("FAIL single_latency: got start %0d want 2", (dec_s.size() > 0) ? dec_s[0] : -1); else pass_cnt++;
    total_cnt++; if (first_idle() != 162) $display("FAIL single_busy_drop: got %0d want 162", first_idle()); else pass_cnt++;
    total_cnt++; if (dec_bad != 0) $display("FAIL single_framing: got %0d bad frames want 0", dec_bad); else pass_cnt++;
  endtask

  task automatic test_eos_suffix();
    logic [7:0] want [3];
    int bad;
    want[0] = 8'h78; want[1] = 8'h0D; want[2] = 8'h0A;
    start_cap();
    push_byte(8'h78, 1'b1);
    char_valid = 0;
    char_eos = 0;
    wait_idle(800);
    stop_cap();
    decode(0, 16);
    total_cnt++; if (dec_b.size() != 3) $display("FAIL eos_count: got %0d want 3", dec_b.size()); else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 3 && k < dec_b.size(); k++)
      if (dec_b[k] !== want[k] || dec_s[k] != 2 + 160*k) bad++;
    total_cnt++; if (bad != 0) $display("FAIL eos_frames: got %0d wrong byte/start want 0", bad); else pass_cnt++;
    total_cnt++; if (first_idle() != 482) $display("FAIL eos_busy_drop: got %0d want 482", first_idle()); else pass_cnt++;
  endtask

  task automatic test_fill();
    int bad;
    start_cap();
    for (int k = 0; k < 9; k++) push_byte(8'h30 + 8'(k), 1'b0);
    char_valid = 0;
    total_cnt++; if (fifo_level !== 4'd8 || char_ready !== 1'b0) $display("FAIL fill_full: level %0d ready %0b want 8/0", fifo_level, char_ready); else pass_cnt++;
    wait_idle(2000);
    stop_cap();
    decode(0, 16);
    bad = 0;
    for (int k = 0; k < dec_b.size(); k++) if (dec_b[k] !== 8'h30 + 8'(k)) bad++;
    total_cnt++; if (dec_b.size() != 9 || bad != 0) $display("FAIL fill_order: got %0d bytes %0d wrong want 9/0", dec_b.size(), bad); else pass_cnt++;
    total_cnt++; if (dec_s.size() != 9 || dec_s[0] != 2 || dec_s[8] != 2 + 8*160) $display("FAIL fill_timing: got %0d frames want 9 back-to-back from 2", dec_s.size()); else pass_cnt++;
    total_cnt++; if (lvl_max != 8) $display("FAIL fill_level_max: got %0d want 8", lvl_max); else pass_cnt++;
    total_cnt++; if (rdy_bad != 0) $display("FAIL fill_ready_rule: got %0d violations want 0", rdy_bad); else pass_cnt++;
  endtask

  task automatic test_full_pop();
    int guard, refused_lvl, acc_lvl, bad;
    logic prev_rdy;
    start_cap();
    for (int k = 0; k < 9; k++) push_byte(8'h60 + 8'(k), 1'b0);
    char_in = 8'h7A;
    prev_rdy = char_ready;
    refused_lvl = -1;
    acc_lvl = -1;
    guard = 0;
    while (guard < 400) begin
      @(negedge clk);
      guard++;
      if (prev_rdy) begin
        acc_lvl = int'(fifo_level);
        break;
      end
      if (char_ready && refused_lvl < 0) refused_lvl = int'(fifo_level);
      prev_rdy = char_ready;
    end
    char_valid = 0;
    total_cnt++; if (refused_lvl != 7) $display("FAIL full_refused: got level %0d want 7", refused_lvl); else pass_cnt++;
    total_cnt++; if (acc_lvl != 8) $display("FAIL full_accept_next: got level %0d want 8", acc_lvl); else pass_cnt++;
    wait_idle(2500);
    stop_cap();
    decode(0, 16);
    bad = 0;
    for (int k = 0; k < dec_b.size(); k++)
      if (dec_b[k] !== ((k < 9) ? 8'h60 + 8'(k) : 8'h7A)) bad++;
    total_cnt++; if (dec_b.size() != 10 || bad != 0) $display("FAIL full_order: got %0d bytes %0d wrong want 10/0", dec_b.size(), bad); else pass_cnt++;
    total_cnt++; if (lvl_max != 8) $display("FAIL full_level_max: got %0d want 8", lvl_max); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int highs;
    start_cap();
    push_byte(8'h55, 1'b0);
    push_byte(8'h01, 1'b1);
    push_byte(8'h02, 1'b0);
    push_byte(8'h03, 1'b0);
    char_valid = 0;
    char_eos = 0;
    repeat (77) @(negedge clk);
    total_cnt++; if (fifo_level !== 4'd3 || busy !== 1'b1) $display("FAIL midreset_pre: level %0d busy %0b want 3/1", fifo_level, busy); else pass_cnt++;
    #1 cap_en = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    total_cnt++; if (tx !== 1'b1) $display("FAIL midreset_tx: got %0b want 1", tx); else pass_cnt++;
    total_cnt++; if (fifo_level !== 4'd0 || busy !== 1'b0 || char_ready !== 1'b1) $display("FAIL midreset_state: level %0d busy %0b ready %0b want 0/0/1", fifo_level, busy, char_ready); else pass_cnt++;
    start_cap();
    repeat (400) @(negedge clk);
    stop_cap();
    decode(0, 16);
    highs = 0;
    foreach (busy_a[k]) if (busy_a[k]) highs++;
    total_cnt++; if (dec_b.size() != 0 || highs != 0) $display("FAIL midreset_quiet: got %0d frames %0d busy cycles want 0/0", dec_b.size(), highs); else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    logic [7:0] exp_q[$];
    logic [7:0] cur;
    logic       cur_e, pending;
    int accepted, guard, bad;
    @(posedge clk);
    cap_b.delete();
    cap_en_s = 1;
    accepted = 0;
    guard = 0;
    pending = 0;
    cur = 0;
    cur_e = 0;
    while (accepted < 200 && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (!pending) begin
        cur = 8'($urandom);
        cur_e = ($urandom_range(0, 3) == 0);
        pending = 1;
      end
      s_valid = ($urandom_range(0, 3) != 0);
      s_char_in = s_valid ? cur : 8'($urandom);
      s_eos = s_valid ? cur_e : 1'($urandom);
      if (s_valid && s_ready) begin
        exp_q.push_back(cur);
        if (cur_e) begin
          exp_q.push_back(8'h0D);
          exp_q.push_back(8'h0A);
        end
        accepted++;
        pending = 0;
      end
    end
    @(negedge clk);
    s_valid = 0;
    total_cnt++; if (accepted != 200) $display("FAIL sb_accept: got %0d want 200", accepted); else pass_cnt++;
    guard = 0;
    while (s_busy !== 1'b0 && guard < 8000) begin
      @(negedge clk);
      guard++;
    end
    total_cnt++; if (guard >= 8000) $display("FAIL sb_drain: busy %0b after %0d cycles want 0", s_busy, guard); else pass_cnt++;
    repeat (4) @(negedge clk);
    #1 cap_en_s = 0;
    decode(1, 2);
    bad = 0;
    for (int k = 0; k < dec_b.size() && k < exp_q.size(); k++) if (dec_b[k] !== exp_q[k]) bad++;
    total_cnt++; if (dec_b.size() != exp_q.size()) $display("FAIL sb_count: got %0d want %0d", dec_b.size(), exp_q.size()); else pass_cnt++;
    total_cnt++; if (bad != 0 || dec_bad != 0) $display("FAIL sb_data: got %0d wrong %0d bad frames want 0/0", bad, dec_bad); else pass_cnt++;
  endtask

  initial begin
    clk = 0;
    rst = 1;
    char_in = 0; char_eos = 0; char_valid = 0;
    s_char_in = 0; s_eos = 0; s_valid = 0;
    test_reset();
    test_single();
    test_eos_suffix();
    test_fill();
    test_full_pop();
    test_reset_mid();
    test_scoreboard();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
